bcd2bin: RTL and testbench

- Sequential BCD-to-binary converter using the reverse double-dabble algorithm: shift right, then subtract 3 from any BCD digit of 8 or more.
- Accepts four packed BCD digits (0..9999) and returns a 14-bit unsigned binary value after a fixed number of cycles.
- Pairs with the existing binary-to-BCD converter. Used where decimal values (UART-entered digits, preset stopwatch times) must become binary counts.
- Uses the same start/ready/done_tick handshake as the rest of the datapath.

---
 rtl/bcd2bin_if.sv | 32 +++
 rtl/bcd2bin.sv | 118 +++++++++++
 tb/tb_bcd2bin.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/bcd2bin_if.sv
// ---------------------------------------------------------------------------
// bcd2bin_if
// Handshake and data bundle for the BCD-to-binary converter.
//   start      : conversion request, honoured only while ready=1
//   bcd3..bcd0 : packed BCD digits, thousands down to units
//   ready      : converter is idle and will accept start
//   done_tick  : one-cycle pulse when bin/err carry a fresh result
//   err        : last completed request contained a digit above 9
//   bin        : 14-bit binary result of the last completed request
// The master modport drives requests; the slave modport is the converter.
// ---------------------------------------------------------------------------
interface bcd2bin_if;
  logic        start;
  logic [3:0]  bcd3;
  logic [3:0]  bcd2;
  logic [3:0]  bcd1;
  logic [3:0]  bcd0;
  logic        ready;
  logic        done_tick;
  logic        err;
  logic [13:0] bin;

  modport master (
    output start, bcd3, bcd2, bcd1, bcd0,
    input  ready, done_tick, err, bin
  );

  modport slave (
    input  start, bcd3, bcd2, bcd1, bcd0,
    output ready, done_tick, err, bin
  );
endinterface

// File: rtl/bcd2bin.sv
// ---------------------------------------------------------------------------
// bcd2bin
// Sequential four-digit BCD to 14-bit binary converter (reverse double
// dabble). Each iteration shifts {d3,d2,d1,d0,b} right by one and then
// subtracts 3 from every BCD digit that reached 8 or more. Fourteen
// iterations move all the weight into b.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high reset
//   bus   : bcd2bin_if.slave (start/ready/done_tick handshake, digits in,
//           bin/err out)
// Timing from the edge that accepts start (T): valid input gives done_tick
// at T+15; an invalid digit gives done_tick at T+1 with err=1 and bin=0.
// ---------------------------------------------------------------------------
module bcd2bin (
  input  logic      clk,
  input  logic      reset,
  bcd2bin_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OP   = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [3:0] ITERATIONS = 4'd14;

  state_t      state, state_next;
  logic [29:0] sr, sr_next;        // {d3, d2, d1, d0, b[13:0]}
  logic [3:0]  n, n_next;
  logic [13:0] bin_q, bin_next;
  logic        err_q, err_next;

  logic        bad_digit;
  logic [29:0] shifted;
  logic [29:0] corrected;

  // Undo the doubling that a digit would have received in double dabble.
  function automatic logic [3:0] fix_digit(input logic [3:0] d);
    return (d >= 4'd8) ? d - 4'd3 : d;
  endfunction

  assign bad_digit = (bus.bcd3 > 4'd9) || (bus.bcd2 > 4'd9) ||
                     (bus.bcd1 > 4'd9) || (bus.bcd0 > 4'd9);

  assign shifted   = {1'b0, sr[29:1]};
  assign corrected = {fix_digit(shifted[29:26]), fix_digit(shifted[25:22]),
                      fix_digit(shifted[21:18]), fix_digit(shifted[17:14]),
                      shifted[13:0]};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; every register here is reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      sr    <= '0;
      n     <= '0;
      bin_q <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_next;
      sr    <= sr_next;
      n     <= n_next;
      bin_q <= bin_next;
      err_q <= err_next;
    end
  end

  // NOTE: every signal written here gets a default first, otherwise a path
  // that skips an assignment would infer a latch.
  always_comb begin
    state_next = state;
    sr_next    = sr;
    n_next     = n;
    bin_next   = bin_q;
    err_next   = err_q;

    case (state)
      S_IDLE: begin
        if (bus.start) begin
          if (bad_digit) begin
            // Reject without touching the shift register.
            err_next   = 1'b1;
            bin_next   = '0;
            state_next = S_DONE;
          end else begin
            sr_next    = {bus.bcd3, bus.bcd2, bus.bcd1, bus.bcd0, 14'b0};
            n_next     = ITERATIONS;
            err_next   = 1'b0;
            state_next = S_OP;
          end
        end
      end

      S_OP: begin
        sr_next = corrected;
        n_next  = n - 4'd1;
        if (n_next == 4'd0) begin
          // Capture the result on the way into done so it is valid
          // together with done_tick.
          bin_next   = corrected[13:0];
          state_next = S_DONE;
        end
      end

      S_DONE: state_next = S_IDLE;

      default: state_next = S_IDLE;
    endcase
  end

  assign bus.ready     = (state == S_IDLE);
  assign bus.done_tick = (state == S_DONE);
  assign bus.bin       = bin_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_bcd2bin.sv
// ---------------------------------------------------------------------------
// tb_bcd2bin
// Directed-vector bench for bcd2bin: reset state, valid and invalid
// conversions with latency, ignored start during conversion, asynchronous
// reset mid-conversion, and a back-to-back strided sweep of 0..9999 with
// start held high.
// ---------------------------------------------------------------------------
module tb_bcd2bin;

  logic clk;
  logic reset;

  bcd2bin_if bus ();

  bcd2bin dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
               tag, got, got, exp, exp);
    end
  endtask

  // Count cycles after the accept edge until done_tick, sampling on the
  // falling edge. Optionally pulses start with other digits at cycle poke_at.
  task automatic wait_done(input string tag, input int poke_at,
                           output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == poke_at) begin
        bus.start = 1'b1;
        bus.bcd3  = 4'd9;
        bus.bcd2  = 4'd8;
        bus.bcd1  = 4'd7;
        bus.bcd0  = 4'd6;
      end else if (lat == poke_at + 1) begin
        bus.start = 1'b0;
      end
      if (!bus.done_tick)
        check({tag, "_busy_ready"}, 32'(bus.ready), 32'd0);
    end while (!bus.done_tick && lat < 40);
    if (lat >= 40)
      check({tag, "_timeout"}, 32'(lat), 32'd15);
  endtask

  task automatic request(input string tag,
                         input logic [3:0] d3, input logic [3:0] d2,
                         input logic [3:0] d1, input logic [3:0] d0,
                         input int poke_at, input logic [13:0] exp_bin,
                         input logic exp_err, input int exp_lat);
    int lat;
    @(negedge clk);
    check({tag, "_ready_in"}, 32'(bus.ready), 32'd1);
    bus.bcd3  = d3;
    bus.bcd2  = d2;
    bus.bcd1  = d1;
    bus.bcd0  = d0;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    wait_done(tag, poke_at, lat);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_bin"}, 32'(bus.bin), 32'(exp_bin));
    check({tag, "_err"}, 32'(bus.err), 32'(exp_err));
    @(negedge clk);
    check({tag, "_ready_out"}, 32'(bus.ready), 32'd1);
    check({tag, "_tick_low"}, 32'(bus.done_tick), 32'd0);
    check({tag, "_bin_hold"}, 32'(bus.bin), 32'(exp_bin));
  endtask

  // Start a valid conversion and hit reset seven cycles in.
  task automatic reset_mid(input string tag);
    @(negedge clk);
    bus.bcd3  = 4'd5;
    bus.bcd2  = 4'd5;
    bus.bcd1  = 4'd5;
    bus.bcd0  = 4'd5;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (7) @(negedge clk);
    check({tag, "_pre_ready"}, 32'(bus.ready), 32'd0);
    reset = 1'b1;
    #1;
    check({tag, "_ready"}, 32'(bus.ready), 32'd1);
    check({tag, "_tick"}, 32'(bus.done_tick), 32'd0);
    check({tag, "_bin"}, 32'(bus.bin), 32'd0);
    check({tag, "_err"}, 32'(bus.err), 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int lat;
    int idle_wait;
    bus.start = 1'b0;
    bus.bcd3  = 4'd0;
    bus.bcd2  = 4'd0;
    bus.bcd1  = 4'd0;
    bus.bcd0  = 4'd0;
    reset     = 1'b1;
    #2;
    check("rst_ready", 32'(bus.ready), 32'd1);
    check("rst_tick", 32'(bus.done_tick), 32'd0);
    check("rst_bin", 32'(bus.bin), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    request("v1234", 4'd1, 4'd2, 4'd3, 4'd4, -5, 14'h04D2, 1'b0, 15);
    request("v9999", 4'd9, 4'd9, 4'd9, 4'd9, -5, 14'h270F, 1'b0, 15);
    request("v0000", 4'd0, 4'd0, 4'd0, 4'd0, -5, 14'd0,    1'b0, 15);
    request("bad_a", 4'd0, 4'd0, 4'hA, 4'd0, -5, 14'd0,    1'b1, 1);
    request("v0050", 4'd0, 4'd0, 4'd5, 4'd0, -5, 14'd50,   1'b0, 15);
    request("bad_f", 4'hF, 4'd1, 4'd2, 4'd3, -5, 14'd0,    1'b1, 1);
    // start pulsed at T+5 with 9876 while busy must be ignored.
    request("ignore", 4'd4, 4'd3, 4'd2, 4'd1, 5, 14'd4321, 1'b0, 15);
    // The extra pulse must not have queued a conversion.
    @(negedge clk);
    check("ignore_no_queue", 32'(bus.ready), 32'd1);

    reset_mid("rst_after_valid");
    request("post_rst1", 4'd0, 4'd8, 4'd0, 4'd7, -5, 14'd807, 1'b0, 15);
    request("bad_b", 4'd0, 4'hB, 4'd0, 4'd0, -5, 14'd0, 1'b1, 1);
    reset_mid("rst_after_err");
    request("post_rst2", 4'd7, 4'd0, 4'd9, 4'd1, -5, 14'd7091, 1'b0, 15);

    // Back-to-back sweep with start held high: one result every 16 cycles.
    @(negedge clk);
    bus.start = 1'b1;
    for (int v = 0; v <= 9999; v += 7) begin
      idle_wait = 0;
      while (!bus.ready && idle_wait < 40) begin
        @(negedge clk);
        idle_wait++;
      end
      if (v != 0)
        check("b2b_gap", 32'(idle_wait), 32'd1);
      bus.bcd3 = 4'(v / 1000);
      bus.bcd2 = 4'((v / 100) % 10);
      bus.bcd1 = 4'((v / 10) % 10);
      bus.bcd0 = 4'(v % 10);
      @(posedge clk);
      wait_done("b2b", -5, lat);
      check("b2b_lat", 32'(lat), 32'd15);
      check("b2b_bin", 32'(bus.bin), 32'(v));
      check("b2b_err", 32'(bus.err), 32'd0);
    end
    bus.start = 1'b0;
    @(negedge clk);
    check("end_ready", 32'(bus.ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

endmodule
